// File: rtl/addsub_rr_arbiter_if.sv
// Bundle of request, shared add/sub unit and response signals around the
// round-robin add/sub arbiter. The arbiter uses the slave view; the clients,
// the shared unit and the response consumer together form the master view.
interface addsub_rr_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_op;

  logic [N-1:0]      as_a;
  logic [N-1:0]      as_b;
  logic              as_op;
  logic [N-1:0]      as_s;
  logic              as_cout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_s;
  logic              rsp_cout;
  logic              rsp_ovf;
  logic              busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, as_s, as_cout, rsp_ready,
    output req_ready, as_a, as_b, as_op,
    output rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, as_s, as_cout, rsp_ready,
    input  req_ready, as_a, as_b, as_op,
    input  rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf, busy
  );
endinterface

// File: rtl/addsub_rr_arbiter.sv
// Round-robin sequencer sharing one external N-bit adder-subtractor among
// NREQ requesters. One operation is in flight at a time:
// IDLE (grant, load operands) -> EXEC (unit settles, capture) -> RESP (hand off).
//
// state | meaning
// IDLE  | waiting for a request; req_ready is the combinational grant
// EXEC  | operands held on as_*, result captured at the end of the cycle
// RESP  | result presented on rsp_*, waiting for rsp_ready
module addsub_rr_arbiter #(
  parameter int N    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic               clk,
  input logic               rst,
  addsub_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id;

  logic            gnt_found;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] gnt_onehot;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;
  logic            sel_op;

  logic [N-1:0]    as_a_q;
  logic [N-1:0]    as_b_q;
  logic            as_op_q;
  logic            rsp_valid_q;
  logic [IDW-1:0]  rsp_id_q;
  logic [N-1:0]    rsp_s_q;
  logic            rsp_cout_q;
  logic            rsp_ovf_q;

  // Rotating priority search starting at ptr; first valid requester wins.
  always_comb begin
    int cand;
    cand       = 0;
    gnt_found  = 1'b0;
    gnt_id     = '0;
    gnt_onehot = '0;
    sel_a      = '0;
    sel_b      = '0;
    sel_op     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!gnt_found && (j == cand) && bus.req_valid[j]) begin
          gnt_found = 1'b1;
          gnt_id    = IDW'(j);
        end
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (gnt_found && (int'(gnt_id) == j)) begin
        gnt_onehot[j] = 1'b1;
        sel_a         = bus.req_a[j*N +: N];
        sel_b         = bus.req_b[j*N +: N];
        sel_op        = bus.req_op[j];
      end
    end
  end

  // Operation sequencer with registered unit inputs and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      id          <= '0;
      as_a_q      <= '0;
      as_b_q      <= '0;
      as_op_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            as_a_q  <= sel_a;
            as_b_q  <= sel_b;
            as_op_q <= sel_op;
            id      <= gnt_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_s_q     <= bus.as_s;
          rsp_cout_q  <= bus.as_cout;
          rsp_id_q    <= id;
          // Signed overflow: operands (B inverted for subtract) agree in sign
          // but the result sign differs.
          rsp_ovf_q   <= (as_a_q[N-1] == (as_b_q[N-1] ^ as_op_q)) &&
                         (bus.as_s[N-1] != as_a_q[N-1]);
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr         <= (int'(id) == NREQ - 1) ? '0 : id + IDW'(1);
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant is only offered from IDLE and never while reset is held.
  assign bus.req_ready = (state == IDLE && !rst) ? gnt_onehot : '0;
  assign bus.as_a      = as_a_q;
  assign bus.as_b      = as_b_q;
  assign bus.as_op     = as_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: doc/addsub_rr_arbiter.md
Name: addsub_rr_arbiter

Overview:
- Round-robin arbiter/sequencer that shares one external N-bit adder-subtractor among NREQ requesters.
- Accepts one operation at a time over a per-requester valid/ready handshake and drives the shared unit's A/B/Op inputs from registers.
- Captures the unit's S/Cout and returns the result, tagged with the requester ID, over a valid/ready response channel.
- Sits between client blocks and a single ripple-carry add/sub instance so that only one datapath is needed.

Parameters:
N, 4, operand/result width in bits (>=2)
NREQ, 4, number of requesters (2..8)
IDW, 2, requester ID width; must satisfy 2**IDW >= NREQ

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  request pending, one bit per requester
req_ready  output  NREQ  grant/accept, one-hot or zero
req_a  input  NREQ*N  operand A, requester i at bits [i*N +: N]
req_b  input  NREQ*N  operand B, same packing
req_op  input  NREQ  0 = add, 1 = subtract (A-B)
as_a  output  N  to shared unit A
as_b  output  N  to shared unit B
as_op  output  1  to shared unit Op
as_s  input  N  from shared unit S
as_cout  input  1  from shared unit Cout
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  IDW  index of the served requester
rsp_s  output  N  result
rsp_cout  output  1  carry out (for subtract, 1 = no borrow)
rsp_ovf  output  1  two's-complement signed overflow
busy  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock `clk`; reset `rst` is synchronous, active-high.
- Reset values (taken at the clk edge with rst=1):
  - state=IDLE, rr pointer ptr=0.
  - as_a/as_b/as_op=0.
  - rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, rsp_ovf=0.
  - busy=0; req_ready=0 while rst is high.
- State IDLE:
  - req_ready is combinational (Mealy). Grant g is the first i with req_valid[i]=1, searching ptr, ptr+1, ..., wrapping mod NREQ.
  - req_ready[g]=1 and all other bits 0; if no req_valid bit is set, req_ready=0.
  - On an edge with a grant: register as_a=req_a[g], as_b=req_b[g], as_op=req_op[g], and save id=g. Next state is EXEC.
- State EXEC (exactly 1 cycle):
  - as_* are held stable so the shared combinational unit settles.
  - At the edge: rsp_s<=as_s, rsp_cout<=as_cout, rsp_id<=id.
  - rsp_ovf<=(as_a[N-1] == (as_b[N-1]^as_op)) && (as_s[N-1] != as_a[N-1]).
  - rsp_valid<=1. Next state is RESP.
- State RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid<=0, ptr<=(id+1) mod NREQ, next state IDLE.
  - req_ready=0 throughout EXEC and RESP.
- Latency and throughput:
  - Grant cycle to rsp_valid high is 2 cycles.
  - With rsp_ready held high, a new grant is possible 3 cycles after the previous one. Max throughput is 1 op per 3 cycles.
- Fairness: a requester that keeps req_valid high waits at most NREQ-1 other grants.
- Handshake rules:
  - Requesters must hold req_a/req_b/req_op stable while req_valid=1 and req_ready=0.
  - A requester may deassert req_valid before it is granted. It is then simply skipped.
- Outputs between operations: as_* keep their last values in IDLE, with no return to zero.
- Width rules:
  - All arithmetic is modulo 2**N.
  - rsp_id is zero-extended to IDW.
  - Indices >= NREQ are never granted.
- Reset mid-operation: rst in EXEC or RESP aborts the operation. Any pending response is discarded (rsp_valid=0 next cycle), and ptr returns to 0.
- Simultaneous events:
  - rsp_ready asserted in the same cycle rsp_valid first rises is a valid handshake.
  - A request arriving during RESP is not granted until the cycle after the return to IDLE.

Test Plan:
- Reset, then a single op: req_valid=0001, req_a[0]=4'h5, req_b[0]=4'h3, op=0, rsp_ready=1 → req_ready=0001 in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_s=4'h8, rsp_cout=0, rsp_ovf=1.
- Subtract with borrow: requester 2, A=4'h3, B=4'h5, op=1 → rsp_s=4'hE, rsp_cout=0, rsp_ovf=0, rsp_id=2. Then A=4'h5, B=4'h3, op=1 → rsp_s=4'h2, rsp_cout=1.
- Round-robin: req_valid=1111 held, rsp_ready=1 → grant order 0,1,2,3,0 on consecutive grants, grants exactly 3 cycles apart; no requester is granted twice before all others are served.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises → rsp_* stable, busy=1, req_ready=0000. Raising rsp_ready gives one handshake and the return to IDLE.
- Reset mid-op: assert rst during EXEC → next cycle rsp_valid=0, busy=0, ptr=0. With req_valid=1010 afterwards, the grant goes to requester 1.
- Withdrawn request: req_valid=0100 for 1 cycle while busy, then 0000 → no grant to requester 2 and no response produced.
